// File: rtl/paicore_hs_pkg.sv
// Shared constants and types for the PAICORE two-channel handshake receiver.
// Build option: PAICORE_HS_SYNC_EN adds a SYNC_N-flop request synchronizer per channel.
package paicore_hs_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned FW     = 2 * DW;
  localparam int unsigned SYNC_N = 2;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    WAIT_LO = 2'd2
  } chan_state_e;

  // Two link words paired into one frame; hi is the first word received.
  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } frame_t;

endpackage

// File: rtl/paicore_hs_rx_chan.sv
// One 4-phase request/acknowledge responder that pairs two link words into a frame.
// Build option: PAICORE_HS_SYNC_EN routes the request through a SYNC_N-flop synchronizer.
module paicore_hs_rx_chan
  import paicore_hs_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx_enable,
  input  logic          i_request,
  input  logic [DW-1:0] i_din,
  input  logic          i_clear,
  output logic          o_ack,
  output frame_t        o_frame,
  output logic          o_frame_vld
);

  chan_state_e r_state;
  chan_state_e w_state_nxt;
  logic        w_req_s;
  logic        w_capture;
  logic        w_release;
  logic        r_ack;
  logic        r_half_sel;
  logic        r_frame_vld;
  frame_t      r_frame;

`ifdef PAICORE_HS_SYNC_EN
  logic [SYNC_N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= SYNC_N'({r_sync, i_request});
    end
  end

  assign w_req_s = r_sync[SYNC_N-1];
`else
  assign w_req_s = i_request;
`endif

  // A pending full frame withholds the next acknowledge until the merge drains it.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_s && i_rx_enable && !r_frame_vld) begin
          w_state_nxt = ACK;
          w_capture   = 1'b1;
        end
      end
      ACK: begin
        w_state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!w_req_s) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_half_sel  <= 1'b0;
      r_frame_vld <= 1'b0;
      r_frame     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt != IDLE);
      if (w_capture) begin
        if (r_half_sel) begin
          r_frame.lo <= i_din;
        end else begin
          r_frame.hi <= i_din;
        end
      end
      if (w_release) begin
        r_half_sel <= ~r_half_sel;
      end
      if (w_capture && r_half_sel) begin
        r_frame_vld <= 1'b1;
      end else if (i_clear) begin
        r_frame_vld <= 1'b0;
      end
    end
  end

  assign o_ack       = r_ack;
  assign o_frame     = r_frame;
  assign o_frame_vld = r_frame_vld;

endmodule

// File: rtl/paicore_hs_rx_2c.sv
// Two-channel PAICORE link receiver merging paired frames round-robin onto an AXI4-Stream master.
// Build option: PAICORE_HS_SYNC_EN enables request synchronizers inside each channel.
module paicore_hs_rx_2c
  import paicore_hs_pkg::*;
(
  input  logic          m_axis_aclk,
  input  logic          m_axis_aresetn,
  input  logic          rx_enable,
  input  logic [31:0]   oFrameNumMax,
  input  logic          request_C0,
  input  logic [DW-1:0] din_C0,
  output logic          acknowledge_C0,
  input  logic          request_C1,
  input  logic [DW-1:0] din_C1,
  output logic          acknowledge_C1,
  input  logic          m_axis_tready,
  output logic [FW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic          m_axis_tvalid,
  output logic [31:0]   frame_cnt,
  output logic          o_rx_done
);

  frame_t        w_frame0;
  frame_t        w_frame1;
  logic          w_vld0;
  logic          w_vld1;
  logic          w_clr0;
  logic          w_clr1;
  logic          w_accept;
  logic          w_load;
  logic          w_any;
  logic          w_dual;
  logic          w_gnt;
  logic          w_last_nxt;
  logic [31:0]   w_cnt_nxt;
  frame_t        w_frame_sel;

  logic          r_rr;
  logic          r_tvalid;
  logic          r_tlast;
  logic [FW-1:0] r_tdata;
  logic [31:0]   r_cnt;
  logic          r_done;

  paicore_hs_rx_chan u_chan0 (
    .clk         (m_axis_aclk),
    .rst_n       (m_axis_aresetn),
    .i_rx_enable (rx_enable),
    .i_request   (request_C0),
    .i_din       (din_C0),
    .i_clear     (w_clr0),
    .o_ack       (acknowledge_C0),
    .o_frame     (w_frame0),
    .o_frame_vld (w_vld0)
  );

  paicore_hs_rx_chan u_chan1 (
    .clk         (m_axis_aclk),
    .rst_n       (m_axis_aresetn),
    .i_rx_enable (rx_enable),
    .i_request   (request_C1),
    .i_din       (din_C1),
    .i_clear     (w_clr1),
    .o_ack       (acknowledge_C1),
    .o_frame     (w_frame1),
    .o_frame_vld (w_vld1)
  );

  // tlast is judged against the count as it will stand after this edge's accept.
  always_comb begin
    w_accept    = r_tvalid & m_axis_tready;
    w_load      = ~r_tvalid | m_axis_tready;
    w_any       = w_vld0 | w_vld1;
    w_dual      = w_vld0 & w_vld1;
    w_gnt       = w_dual ? r_rr : w_vld1;
    w_clr0      = w_load & w_vld0 & (w_gnt == CH0);
    w_clr1      = w_load & w_vld1 & (w_gnt == CH1);
    w_frame_sel = (w_gnt == CH1) ? w_frame1 : w_frame0;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_cnt_nxt = r_tlast ? 32'd0 : (r_cnt + 32'd1);
    end
    w_last_nxt  = (oFrameNumMax != 32'd0) && (w_cnt_nxt == (oFrameNumMax - 32'd1));
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_rr     <= CH0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= w_accept & r_tlast;
      if (w_load) begin
        r_tvalid <= w_any;
        r_tlast  <= w_any & w_last_nxt;
        if (w_any) begin
          r_tdata <= FW'(w_frame_sel);
        end
        if (w_dual) begin
          r_rr <= ~r_rr;
        end
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign frame_cnt     = r_cnt;
  assign o_rx_done     = r_done;

endmodule

// File: tb/tb_paicore_hs_rx_2c.sv
// Directed bench for paicore_hs_rx_2c: handshakes, pairing, round-robin merge, stall, tlast, reset.
module tb_paicore_hs_rx_2c;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_enable = 1'b0;
  logic [31:0] max_frames = 32'd0;
  logic        request_C0 = 1'b0;
  logic [31:0] din_C0 = 32'd0;
  logic        request_C1 = 1'b0;
  logic [31:0] din_C1 = 32'd0;
  logic        tready = 1'b0;
  logic        acknowledge_C0;
  logic        acknowledge_C1;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic [31:0] frame_cnt;
  logic        rx_done;

  logic [64:0] beats[$];
  int          n_done = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_chk  = 0;

  always #5 clk = ~clk;

  paicore_hs_rx_2c dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .rx_enable      (rx_enable),
    .oFrameNumMax   (max_frames),
    .request_C0     (request_C0),
    .din_C0         (din_C0),
    .acknowledge_C0 (acknowledge_C0),
    .request_C1     (request_C1),
    .din_C1         (din_C1),
    .acknowledge_C1 (acknowledge_C1),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tlast   (tlast),
    .m_axis_tvalid  (tvalid),
    .frame_cnt      (frame_cnt),
    .o_rx_done      (rx_done)
  );

  // Record every accepted beat as {tlast, tdata}.
  always @(posedge clk) begin
    if (rst_n && tvalid && tready) beats.push_back({tlast, tdata});
  end

  always @(negedge clk) begin
    if (rx_done) n_done++;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass += 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Concurrent 4-phase transfer on the enabled channels, driven at falling edges.
  task automatic hs(input logic e0, input logic [31:0] d0, input logic e1, input logic [31:0] d1);
    int ph0;
    int ph1;
    ph0 = e0 ? 1 : 3;
    ph1 = e1 ? 1 : 3;
    if (e0) begin din_C0 = d0; request_C0 = 1'b1; end
    if (e1) begin din_C1 = d1; request_C1 = 1'b1; end
    for (int c = 0; c < 100 && (ph0 != 3 || ph1 != 3); c++) begin
      @(negedge clk);
      if (ph0 == 1 && acknowledge_C0) begin request_C0 = 1'b0; ph0 = 2; end
      else if (ph0 == 2 && !acknowledge_C0) ph0 = 3;
      if (ph1 == 1 && acknowledge_C1) begin request_C1 = 1'b0; ph1 = 2; end
      else if (ph1 == 2 && !acknowledge_C1) ph1 = 3;
    end
    chk("hs_done", 72'({ph0 == 3, ph1 == 3}), 72'(2'b11));
  endtask

  task automatic wait_ack(input logic ch, input logic val, input string tag);
    for (int c = 0; c < 100; c++) begin
      if ((ch ? acknowledge_C1 : acknowledge_C0) === val) break;
      @(negedge clk);
    end
    chk(tag, 72'(ch ? acknowledge_C1 : acknowledge_C0), 72'(val));
  endtask

  task automatic wait_beats(input int n, input string tag);
    for (int c = 0; c < 200 && beats.size() < n; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(tag, 72'(beats.size()), 72'(n));
  endtask

  initial begin
    int b0;
    int d0;

    // Reset state
    rx_enable  = 1'b1;
    tready     = 1'b1;
    max_frames = 32'd1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 72'({acknowledge_C0, acknowledge_C1, tvalid, tlast, rx_done}), 72'(0));
    chk("rst_tdata", 72'(tdata), 72'(0));
    chk("rst_cnt", 72'(frame_cnt), 72'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame on C0 with one-frame packets
    b0 = beats.size(); d0 = n_done;
    hs(1'b1, 32'hAAAA0001, 1'b0, 32'd0);
    hs(1'b1, 32'hAAAA0002, 1'b0, 32'd0);
    wait_beats(b0 + 1, "t1_nbeats");
    chk("t1_beat", 72'(beats[b0]), 72'({1'b1, 64'hAAAA0001AAAA0002}));
    chk("t1_done", 72'(n_done - d0), 72'(1));
    chk("t1_cnt", 72'(frame_cnt), 72'(0));

    // Three-frame packets, six frames on C1
    max_frames = 32'd3;
    b0 = beats.size(); d0 = n_done;
    for (int i = 0; i < 12; i++) hs(1'b0, 32'd0, 1'b1, 32'hC1000000 + 32'(i));
    wait_beats(b0 + 6, "t6_nbeats");
    for (int k = 0; k < 6; k++) chk("t6_tlast", 72'(beats[b0 + k][64]), 72'(k == 2 || k == 5));
    chk("t6_beat3", 72'(beats[b0 + 2][63:0]), 72'(64'hC1000004C1000005));
    chk("t6_done", 72'(n_done - d0), 72'(2));
    chk("t6_cnt", 72'(frame_cnt), 72'(0));

    // Endless stream: no tlast
    max_frames = 32'd0;
    b0 = beats.size(); d0 = n_done;
    for (int i = 0; i < 8; i++) hs(1'b1, 32'hD0000000 + 32'(i), 1'b0, 32'd0);
    wait_beats(b0 + 4, "t7_nbeats");
    for (int k = 0; k < 4; k++) chk("t7_tlast", 72'(beats[b0 + k][64]), 72'(0));
    chk("t7_done", 72'(n_done - d0), 72'(0));
    chk("t7_cnt", 72'(frame_cnt), 72'(4));

    // Both channels complete in the same cycle: C0 first
    b0 = beats.size();
    hs(1'b1, 32'h00000010, 1'b1, 32'h00000020);
    hs(1'b1, 32'h00000011, 1'b1, 32'h00000021);
    wait_beats(b0 + 2, "t2_nbeats");
    chk("t2_first", 72'(beats[b0]), 72'({1'b0, 64'h0000001000000011}));
    chk("t2_second", 72'(beats[b0 + 1]), 72'({1'b0, 64'h0000002000000021}));
    chk("t2_cnt", 72'(frame_cnt), 72'(6));

    // Reset while acknowledge is high
    hs(1'b1, 32'hBAD00001, 1'b0, 32'd0);
    din_C0 = 32'hBAD00002;
    request_C0 = 1'b1;
    wait_ack(1'b0, 1'b1, "t5_ack_hi");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", 72'(acknowledge_C0), 72'(0));
    chk("t5_rst_tvalid", 72'(tvalid), 72'(0));
    chk("t5_rst_cnt", 72'(frame_cnt), 72'(0));
    @(negedge clk);
    request_C0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b0 = beats.size();
    hs(1'b1, 32'hB0000001, 1'b0, 32'd0);
    hs(1'b1, 32'hB0000002, 1'b0, 32'd0);
    wait_beats(b0 + 1, "t5_nbeats");
    chk("t5_beat", 72'(beats[b0]), 72'({1'b0, 64'hB0000001B0000002}));

    // Output stall with both channels busy
    tready = 1'b0;
    b0 = beats.size();
    hs(1'b1, 32'h30000001, 1'b1, 32'h40000001);
    hs(1'b1, 32'h30000002, 1'b1, 32'h40000002);
    din_C1 = 32'h40000003;
    request_C1 = 1'b1;
    hs(1'b1, 32'h30000003, 1'b0, 32'd0);
    hs(1'b1, 32'h30000004, 1'b0, 32'd0);
    din_C0 = 32'h30000005;
    request_C0 = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_ack1_held", 72'(acknowledge_C1), 72'(0));
    chk("t3_ack0_held", 72'(acknowledge_C0), 72'(0));
    chk("t3_tvalid", 72'(tvalid), 72'(1));
    chk("t3_tdata_hold", 72'(tdata), 72'(64'h3000000130000002));
    chk("t3_no_accept", 72'(beats.size()), 72'(b0));
    tready = 1'b1;
    wait_ack(1'b1, 1'b1, "t3_ack1_rel");
    request_C1 = 1'b0;
    wait_ack(1'b1, 1'b0, "t3_ack1_lo");
    wait_ack(1'b0, 1'b1, "t3_ack0_rel");
    request_C0 = 1'b0;
    wait_ack(1'b0, 1'b0, "t3_ack0_lo");
    hs(1'b0, 32'd0, 1'b1, 32'h40000004);
    wait_beats(b0 + 4, "t3_nbeats4");
    hs(1'b1, 32'h30000006, 1'b0, 32'd0);
    wait_beats(b0 + 5, "t3_nbeats5");
    chk("t3_b0", 72'(beats[b0]),     72'({1'b0, 64'h3000000130000002}));
    chk("t3_b1", 72'(beats[b0 + 1]), 72'({1'b0, 64'h4000000140000002}));
    chk("t3_b2", 72'(beats[b0 + 2]), 72'({1'b0, 64'h3000000330000004}));
    chk("t3_b3", 72'(beats[b0 + 3]), 72'({1'b0, 64'h4000000340000004}));
    chk("t3_b4", 72'(beats[b0 + 4]), 72'({1'b0, 64'h3000000530000006}));

    // rx_enable drops during WAIT_LO
    b0 = beats.size();
    din_C0 = 32'hE0000001;
    request_C0 = 1'b1;
    wait_ack(1'b0, 1'b1, "t4_ack_hi");
    @(negedge clk);
    rx_enable = 1'b0;
    request_C0 = 1'b0;
    wait_ack(1'b0, 1'b0, "t4_completes");
    din_C0 = 32'hE0000002;
    request_C0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_blocked", 72'(acknowledge_C0), 72'(0));
    rx_enable = 1'b1;
    wait_ack(1'b0, 1'b1, "t4_resume");
    request_C0 = 1'b0;
    wait_ack(1'b0, 1'b0, "t4_lo");
    wait_beats(b0 + 1, "t4_nbeats");
    chk("t4_beat", 72'(beats[b0]), 72'({1'b0, 64'hE0000001E0000002}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
